// File: rtl/dram_ctrl_pkg.sv
// Shared types and default sizing for the two-port DRAM array controller.
package dram_ctrl_pkg;

  typedef enum logic {
    SERVE   = 1'b0,
    REFRESH = 1'b1
  } ctrl_state_e;

  localparam int DEFAULT_ADDR_W           = 4;
  localparam int DEFAULT_DATA_W           = 16;
  localparam int DEFAULT_REFRESH_INTERVAL = 64;
  localparam int DEFAULT_REFRESH_CYCLES   = 1;

endpackage

// File: rtl/dram_ctrl_if.sv
// One requester port: valid/ready request channel plus read response channel.
interface dram_ctrl_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 16
);
  logic              req_valid;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              req_ready;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;

  modport master (
    output req_valid, req_we, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata
  );
endinterface

// File: rtl/dram_ctrl_refresh_timer.sv
// Free-running refresh interval counter; raises pending until the FSM acknowledges it.
module dram_refresh_timer
  import dram_ctrl_pkg::*;
#(
  parameter int REFRESH_INTERVAL = DEFAULT_REFRESH_INTERVAL
) (
  input  logic clk,
  input  logic rst,
  input  logic ack,
  output logic pending
);
  localparam int              CNT_W = $clog2(REFRESH_INTERVAL);
  localparam logic [CNT_W-1:0] LOAD = CNT_W'(REFRESH_INTERVAL - 1);

  logic [CNT_W-1:0] cnt;

  // A new request wins over a simultaneous acknowledge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt     <= LOAD;
      pending <= 1'b0;
    end else begin
      if (cnt == '0) begin
        cnt     <= LOAD;
        pending <= 1'b1;
      end else begin
        cnt <= cnt - CNT_W'(1);
        if (ack) pending <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/dram_ctrl.sv
// Two-port arbiter/sequencer for the dual-port DRAM array with periodic refresh.
module dram_ctrl
  import dram_ctrl_pkg::*;
#(
  parameter int ADDR_W           = DEFAULT_ADDR_W,
  parameter int DATA_W           = DEFAULT_DATA_W,
  parameter int REFRESH_INTERVAL = DEFAULT_REFRESH_INTERVAL,
  parameter int REFRESH_CYCLES   = DEFAULT_REFRESH_CYCLES
) (
  input  logic              clk,
  input  logic              rst,
  dram_ctrl_if.slave        port_a,
  dram_ctrl_if.slave        port_b,
  output logic              mem_we_a,
  output logic              mem_enable_a,
  output logic [ADDR_W-1:0] mem_addr_a,
  output logic [DATA_W-1:0] mem_data_in_a,
  input  logic [DATA_W-1:0] mem_data_out_a,
  output logic              mem_we_b,
  output logic              mem_enable_b,
  output logic [ADDR_W-1:0] mem_addr_b,
  output logic [DATA_W-1:0] mem_data_in_b,
  input  logic [DATA_W-1:0] mem_data_out_b,
  output logic              mem_refresh_en,
  output logic              refresh_busy
);
  localparam int               RCNT_W = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
  localparam logic [RCNT_W-1:0] RLAST = RCNT_W'(REFRESH_CYCLES - 1);

  ctrl_state_e       state, state_nxt;
  logic [RCNT_W-1:0] rcnt, rcnt_nxt;
  logic              pending, ack;
  logic              ptr_b;
  logic              can_serve, conflict, rdy_a, rdy_b, grant_a, grant_b;

  logic              we_a_p1, en_a_p1, we_b_p1, en_b_p1, refresh_p1;
  logic [ADDR_W-1:0] addr_a_p1, addr_b_p1;
  logic [DATA_W-1:0] wdata_a_p1, wdata_b_p1;
  logic              rsp_vld_a_p2, rsp_vld_b_p2;

  dram_refresh_timer #(.REFRESH_INTERVAL(REFRESH_INTERVAL)) u_timer (
    .clk     (clk),
    .rst     (rst),
    .ack     (ack),
    .pending (pending)
  );

  // A pending refresh blocks all grants so the refresh edge is grant-free.
  assign can_serve = (state == SERVE) && !pending;
  assign conflict  = port_a.req_valid && port_b.req_valid &&
                     (port_a.req_addr == port_b.req_addr) &&
                     (port_a.req_we || port_b.req_we);
  assign rdy_a     = can_serve && !(conflict && ptr_b);
  assign rdy_b     = can_serve && !(conflict && !ptr_b);
  assign grant_a   = port_a.req_valid && rdy_a;
  assign grant_b   = port_b.req_valid && rdy_b;

  assign port_a.req_ready = rdy_a;
  assign port_b.req_ready = rdy_b;

  always_comb begin
    state_nxt = state;
    rcnt_nxt  = rcnt;
    ack       = 1'b0;
    case (state)
      SERVE: begin
        if (pending) begin
          state_nxt = REFRESH;
          rcnt_nxt  = '0;
          ack       = 1'b1;
        end
      end
      REFRESH: begin
        if (rcnt == RLAST) state_nxt = SERVE;
        else               rcnt_nxt  = rcnt + RCNT_W'(1);
      end
      default: state_nxt = SERVE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= SERVE;
      rcnt       <= '0;
      ptr_b      <= 1'b0;
      refresh_p1 <= 1'b0;
    end else begin
      state      <= state_nxt;
      rcnt       <= rcnt_nxt;
      refresh_p1 <= (state_nxt == REFRESH);
      if (conflict && can_serve) ptr_b <= ~ptr_b;
    end
  end

  // Stage p1: registered array strobes, address and write data.
  // Stage p2: read response valid, aligned with the array's registered read data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we_a_p1      <= 1'b0;
      en_a_p1      <= 1'b0;
      addr_a_p1    <= '0;
      wdata_a_p1   <= '0;
      we_b_p1      <= 1'b0;
      en_b_p1      <= 1'b0;
      addr_b_p1    <= '0;
      wdata_b_p1   <= '0;
      rsp_vld_a_p2 <= 1'b0;
      rsp_vld_b_p2 <= 1'b0;
    end else begin
      we_a_p1      <= grant_a && port_a.req_we;
      en_a_p1      <= grant_a && !port_a.req_we;
      we_b_p1      <= grant_b && port_b.req_we;
      en_b_p1      <= grant_b && !port_b.req_we;
      if (grant_a)                  addr_a_p1  <= port_a.req_addr;
      if (grant_a && port_a.req_we) wdata_a_p1 <= port_a.req_wdata;
      if (grant_b)                  addr_b_p1  <= port_b.req_addr;
      if (grant_b && port_b.req_we) wdata_b_p1 <= port_b.req_wdata;
      rsp_vld_a_p2 <= en_a_p1;
      rsp_vld_b_p2 <= en_b_p1;
    end
  end

  assign mem_we_a         = we_a_p1;
  assign mem_enable_a     = en_a_p1;
  assign mem_addr_a       = addr_a_p1;
  assign mem_data_in_a    = wdata_a_p1;
  assign mem_we_b         = we_b_p1;
  assign mem_enable_b     = en_b_p1;
  assign mem_addr_b       = addr_b_p1;
  assign mem_data_in_b    = wdata_b_p1;
  assign mem_refresh_en   = refresh_p1;
  assign refresh_busy     = refresh_p1;
  assign port_a.rsp_valid = rsp_vld_a_p2;
  assign port_a.rsp_rdata = mem_data_out_a;
  assign port_b.rsp_valid = rsp_vld_b_p2;
  assign port_b.rsp_rdata = mem_data_out_b;

endmodule
